// File: rtl/mcu_link_controller.sv
// MCU-side endpoint of the 6502-MCU mailbox: TX FIFO into the TX latch, RX latch into a valid/ready register.
// state   | meaning
// T_IDLE  | wait for a queued byte while the mailbox TX latch is free
// T_SETUP | TX_DATA driven one cycle ahead of the load strobe
// T_PULSE | TX_LOAD high
// T_BLIND | ignore TX_AVAIL until the synchronizer reflects the load
// R_RESET | first cycle after reset release
// R_INIT  | RX_ACK pulse that arms RX_READY
// R_IDLE  | wait for DATA_WRITTEN with the output slot free
// R_READ  | RX_OE_N low while RX_DATA settles
// R_ACK   | RX_ACK high
// R_CLEAR | wait for DATA_WRITTEN to drop
module mcu_link_controller #(
  parameter int TX_DEPTH     = 4,
  parameter int PULSE_CYCLES = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int RD_SETTLE    = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        TX_WR,
  input  logic [7:0]  TX_WDATA,
  output logic        TX_FULL,
  output logic        TX_EMPTY,
  output logic        RX_VALID,
  output logic [7:0]  RX_BYTE,
  input  logic        RX_TAKE,
  output logic [7:0]  TX_DATA,
  output logic        TX_LOAD,
  input  logic [7:0]  RX_DATA,
  output logic        RX_OE_N,
  output logic        RX_ACK,
  input  logic        TX_AVAIL,
  input  logic        RX_READY,
  input  logic        DATA_TAKEN,
  input  logic        DATA_WRITTEN,
  output logic [15:0] TX_COUNT,
  output logic [15:0] RX_COUNT
);

  localparam int AW = $clog2(TX_DEPTH);
  localparam int TW = 8;

  typedef enum logic [1:0] {T_IDLE, T_SETUP, T_PULSE, T_BLIND} tx_state_t;
  typedef enum logic [2:0] {R_RESET, R_INIT, R_IDLE, R_READ, R_ACK, R_CLEAR} rx_state_t;

  logic [3:0] sync_q [SYNC_STAGES];
  logic       tx_avail_s, rx_ready_s, data_taken_s, data_written_s;
  logic       unused_flags;

  logic [7:0]    fifo_mem [TX_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          fifo_empty, fifo_full, push, pop;

  tx_state_t     tx_state, tx_state_n;
  logic [TW-1:0] tx_tmr, tx_tmr_n;
  rx_state_t     rx_state, rx_state_n;
  logic [TW-1:0] rx_tmr, rx_tmr_n;
  logic          rx_capture;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {DATA_WRITTEN, DATA_TAKEN, RX_READY, TX_AVAIL};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign tx_avail_s     = sync_q[SYNC_STAGES-1][0];
  assign rx_ready_s     = sync_q[SYNC_STAGES-1][1];
  assign data_taken_s   = sync_q[SYNC_STAGES-1][2];
  assign data_written_s = sync_q[SYNC_STAGES-1][3];

  // RX_READY and DATA_TAKEN are synchronized alongside the others but the sequencing never needs them.
  assign unused_flags = rx_ready_s ^ data_taken_s;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push       = TX_WR && !fifo_full;

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= TX_WDATA;
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_tmr_n   = tx_tmr;
    pop        = 1'b0;
    case (tx_state)
      T_IDLE: begin
        if (!fifo_empty && !tx_avail_s) begin
          pop        = 1'b1;
          tx_state_n = T_SETUP;
        end
      end
      T_SETUP: begin
        tx_state_n = T_PULSE;
        tx_tmr_n   = TW'(PULSE_CYCLES - 1);
      end
      T_PULSE: begin
        if (tx_tmr == '0) begin
          tx_state_n = T_BLIND;
          tx_tmr_n   = TW'(SYNC_STAGES);
        end else begin
          tx_tmr_n = tx_tmr - 1'b1;
        end
      end
      T_BLIND: begin
        if (tx_tmr == '0) tx_state_n = T_IDLE;
        else              tx_tmr_n   = tx_tmr - 1'b1;
      end
      default: tx_state_n = T_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_state <= T_IDLE;
      tx_tmr   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      TX_DATA  <= '0;
      TX_COUNT <= '0;
    end else begin
      tx_state <= tx_state_n;
      tx_tmr   <= tx_tmr_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        TX_DATA <= fifo_mem[rd_ptr[AW-1:0]];
      end
      if (tx_state == T_PULSE && tx_state_n == T_BLIND) TX_COUNT <= TX_COUNT + 16'd1;
    end
  end

  assign TX_LOAD  = (tx_state == T_PULSE);
  assign TX_FULL  = fifo_full;
  assign TX_EMPTY = fifo_empty && (tx_state == T_IDLE);

  always_comb begin
    rx_state_n = rx_state;
    rx_tmr_n   = rx_tmr;
    rx_capture = 1'b0;
    case (rx_state)
      R_RESET: begin
        rx_state_n = R_INIT;
        rx_tmr_n   = TW'(PULSE_CYCLES - 1);
      end
      R_INIT: begin
        if (rx_tmr == '0) rx_state_n = R_IDLE;
        else              rx_tmr_n   = rx_tmr - 1'b1;
      end
      R_IDLE: begin
        // The slot also counts as free when the consumer takes the held byte this same cycle.
        if (data_written_s && (!RX_VALID || RX_TAKE)) begin
          rx_state_n = R_READ;
          rx_tmr_n   = TW'(RD_SETTLE - 1);
        end
      end
      R_READ: begin
        if (rx_tmr == '0) begin
          rx_capture = 1'b1;
          rx_state_n = R_ACK;
          rx_tmr_n   = TW'(PULSE_CYCLES - 1);
        end else begin
          rx_tmr_n = rx_tmr - 1'b1;
        end
      end
      R_ACK: begin
        if (rx_tmr == '0) rx_state_n = R_CLEAR;
        else              rx_tmr_n   = rx_tmr - 1'b1;
      end
      R_CLEAR: begin
        if (!data_written_s) rx_state_n = R_IDLE;
      end
      default: rx_state_n = R_RESET;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_state <= R_RESET;
      rx_tmr   <= '0;
      RX_VALID <= 1'b0;
      RX_BYTE  <= '0;
      RX_COUNT <= '0;
    end else begin
      rx_state <= rx_state_n;
      rx_tmr   <= rx_tmr_n;
      if (rx_capture) begin
        RX_VALID <= 1'b1;
        RX_BYTE  <= RX_DATA;
        RX_COUNT <= RX_COUNT + 16'd1;
      end else if (RX_VALID && RX_TAKE) begin
        RX_VALID <= 1'b0;
      end
    end
  end

  assign RX_OE_N = (rx_state != R_READ);
  assign RX_ACK  = (rx_state == R_INIT) || (rx_state == R_ACK);

endmodule

// File: tb/tb_mcu_link_controller.sv
// Self-checking bench for mcu_link_controller: directed cases from the mailbox protocol,
// then randomized traffic against queue-based TX/RX models acting as the 6502 side.
module tb_mcu_link_controller;
  localparam int TX_DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        TX_WR = 1'b0;
  logic [7:0]  TX_WDATA = '0;
  logic        TX_FULL, TX_EMPTY, RX_VALID, TX_LOAD, RX_OE_N, RX_ACK;
  logic [7:0]  RX_BYTE, TX_DATA;
  logic        RX_TAKE = 1'b0;
  logic [7:0]  RX_DATA = '0;
  logic        TX_AVAIL = 1'b0, RX_READY = 1'b0, DATA_TAKEN = 1'b0, DATA_WRITTEN = 1'b0;
  logic [15:0] TX_COUNT, RX_COUNT;

  mcu_link_controller #(.TX_DEPTH(TX_DEPTH), .PULSE_CYCLES(2), .SYNC_STAGES(2), .RD_SETTLE(2)) dut (
    .CLK(CLK), .RST(RST), .TX_WR(TX_WR), .TX_WDATA(TX_WDATA), .TX_FULL(TX_FULL), .TX_EMPTY(TX_EMPTY),
    .RX_VALID(RX_VALID), .RX_BYTE(RX_BYTE), .RX_TAKE(RX_TAKE), .TX_DATA(TX_DATA), .TX_LOAD(TX_LOAD),
    .RX_DATA(RX_DATA), .RX_OE_N(RX_OE_N), .RX_ACK(RX_ACK), .TX_AVAIL(TX_AVAIL), .RX_READY(RX_READY),
    .DATA_TAKEN(DATA_TAKEN), .DATA_WRITTEN(DATA_WRITTEN), .TX_COUNT(TX_COUNT), .RX_COUNT(RX_COUNT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  int         tx_pushed, rx_written, avail_dly, wr_state, wr_gap, lat, seen, ack_seen;
  logic       load_prev, active;
  logic [7:0] load_data;
  logic [15:0] oe_mask, ack_mask;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic wait_load(input int limit, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!TX_LOAD && cyc < limit);
    check_val("tx_load_seen", TX_LOAD, 1);
  endtask

  task automatic push_byte(input logic [7:0] b);
    TX_WDATA = b;
    TX_WR = 1'b1;
    tick();
    TX_WR = 1'b0;
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    #1;
    check_val("rst_tx_load", TX_LOAD, 0);
    check_val("rst_rx_ack", RX_ACK, 0);
    check_val("rst_rx_oe_n", RX_OE_N, 1);
    check_val("rst_tx_data", TX_DATA, 0);
    check_val("rst_rx_valid", RX_VALID, 0);
    check_val("rst_rx_byte", RX_BYTE, 0);
    check_val("rst_tx_count", TX_COUNT, 0);
    check_val("rst_rx_count", RX_COUNT, 0);
    check_val("rst_tx_empty", TX_EMPTY, 1);
    check_val("rst_tx_full", TX_FULL, 0);
    repeat (3) tick();
    RST = 1'b0;
    check_val("rel_rx_ack_pre", RX_ACK, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_val($sformatf("init_ack_c%0d", k + 1), RX_ACK, (k < 2) ? 1 : 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    apply_reset();

    // Single TX with latency from the push cycle.
    push_byte(8'hA5);
    check_val("tx_empty_c1", TX_EMPTY, 0);
    tick();
    check_val("tx_data_c2", TX_DATA, 8'hA5);
    check_val("tx_load_c2", TX_LOAD, 0);
    tick(); check_val("tx_load_c3", TX_LOAD, 1);
    tick(); check_val("tx_load_c4", TX_LOAD, 1);
    tick(); check_val("tx_load_c5", TX_LOAD, 0);
    check_val("tx_count_1", TX_COUNT, 1);

    // Mailbox latch busy: byte must wait for TX_AVAIL to drop.
    TX_AVAIL = 1'b1;
    repeat (8) tick();
    push_byte(8'h3C);
    seen = 0;
    repeat (20) begin tick(); if (TX_LOAD) seen++; end
    check_val("tx_hold_while_avail", seen, 0);
    TX_AVAIL = 1'b0;
    wait_load(20, lat);
    check_val("tx_avail_drop_latency", lat, 4);
    check_val("tx_data_3c", TX_DATA, 8'h3C);
    TX_AVAIL = 1'b1;
    repeat (10) tick();
    check_val("tx_count_2", TX_COUNT, 2);

    // FIFO fill and overflow drop.
    for (int i = 1; i <= 5; i++) push_byte(i[7:0]);
    check_val("fifo_full", TX_FULL, 1);
    check_val("fifo_not_empty", TX_EMPTY, 0);
    for (int i = 1; i <= 4; i++) begin
      TX_AVAIL = 1'b0;
      wait_load(20, lat);
      check_val($sformatf("fifo_order_%0d", i), TX_DATA, i);
      TX_AVAIL = 1'b1;
      repeat (8) tick();
    end
    check_val("fifo_drained_empty", TX_EMPTY, 1);
    check_val("fifo_drained_full", TX_FULL, 0);
    TX_AVAIL = 1'b0;
    seen = 0;
    repeat (15) begin tick(); if (TX_LOAD) seen++; end
    check_val("fifo_fifth_dropped", seen, 0);
    check_val("tx_count_6", TX_COUNT, 6);

    // Single RX capture with cycle-exact strobes.
    RX_DATA = 8'h5A;
    DATA_WRITTEN = 1'b1;
    oe_mask = '0; ack_mask = '0; lat = 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (!RX_OE_N) oe_mask[k] = 1'b1;
      if (RX_ACK) ack_mask[k] = 1'b1;
      if (RX_VALID && lat == 0) lat = k;
    end
    check_val("rx_oe_window", oe_mask, 16'h0018);
    check_val("rx_ack_window", ack_mask, 16'h0060);
    check_val("rx_valid_latency", lat, 5);
    check_val("rx_byte_5a", RX_BYTE, 8'h5A);
    check_val("rx_count_1", RX_COUNT, 1);
    seen = 0;
    repeat (10) begin tick(); if (!RX_OE_N) seen++; end
    check_val("rx_no_double_capture", seen, 0);
    DATA_WRITTEN = 1'b0;
    repeat (4) tick();

    // Backpressure: second byte waits until the first is taken.
    RX_DATA = 8'h66;
    DATA_WRITTEN = 1'b1;
    seen = 0; ack_seen = 0;
    repeat (15) begin tick(); if (!RX_OE_N) seen++; if (RX_ACK) ack_seen++; end
    check_val("rx_bp_no_oe", seen, 0);
    check_val("rx_bp_no_ack", ack_seen, 0);
    check_val("rx_bp_keep_valid", RX_VALID, 1);
    check_val("rx_bp_keep_byte", RX_BYTE, 8'h5A);
    RX_TAKE = 1'b1;
    tick();
    RX_TAKE = 1'b0;
    lat = 0;
    while (!RX_VALID && lat < 20) begin tick(); lat++; end
    check_val("rx_bp_valid", RX_VALID, 1);
    check_val("rx_byte_66", RX_BYTE, 8'h66);
    check_val("rx_count_2", RX_COUNT, 2);
    repeat (3) tick();
    DATA_WRITTEN = 1'b0;
    repeat (4) tick();
    RX_TAKE = 1'b1;
    tick();
    RX_TAKE = 1'b0;
    check_val("rx_taken", RX_VALID, 0);

    // Reset while TX_LOAD is high.
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    wait_load(20, lat);
    apply_reset();
    seen = 0;
    repeat (15) begin tick(); if (TX_LOAD) seen++; end
    check_val("no_load_after_reset", seen, 0);

    // Randomized traffic: bench plays the 6502 side of both mailbox directions.
    tx_q.delete(); rx_q.delete();
    tx_pushed = 0; rx_written = 0; avail_dly = 0; wr_state = 0; wr_gap = 0;
    load_prev = 1'b0; load_data = '0;
    for (int cyc = 0; cyc < 4300; cyc++) begin
      active = (cyc < 4000);
      tick();
      if (TX_LOAD && !load_prev) begin
        check_val("tx_avail_at_load", TX_AVAIL, 0);
        check_val("tx_load_expected", tx_q.size() > 0, 1);
        if (tx_q.size() > 0) check_val("tx_order", TX_DATA, tx_q.pop_front());
        load_data = TX_DATA;
        TX_AVAIL = 1'b1;
        avail_dly = $urandom_range(0, 15);
      end else if (TX_LOAD) begin
        check_val("tx_data_stable", TX_DATA, load_data);
      end else if (TX_AVAIL) begin
        if (avail_dly == 0) TX_AVAIL = 1'b0;
        else avail_dly--;
      end
      load_prev = TX_LOAD;

      TX_WR = 1'b0;
      if (active && tx_q.size() < TX_DEPTH && $urandom_range(0, 2) == 0) begin
        check_val("tx_full_early", TX_FULL, 0);
        TX_WDATA = 8'($urandom);
        TX_WR = 1'b1;
        tx_q.push_back(TX_WDATA);
        tx_pushed++;
      end

      if (wr_state == 0) begin
        if (wr_gap > 0) wr_gap--;
        else if (active && $urandom_range(0, 3) == 0) begin
          RX_DATA = 8'($urandom);
          DATA_WRITTEN = 1'b1;
          rx_q.push_back(RX_DATA);
          rx_written++;
          wr_state = 1;
        end
      end else if (RX_ACK) begin
        DATA_WRITTEN = 1'b0;
        wr_gap = $urandom_range(4, 10);
        wr_state = 0;
      end

      check_val("ack_oe_overlap", RX_ACK & ~RX_OE_N, 0);
      RX_TAKE = !active || ($urandom_range(0, 2) == 0);
      if (RX_VALID && RX_TAKE) begin
        check_val("rx_take_expected", rx_q.size() > 0, 1);
        if (rx_q.size() > 0) check_val("rx_order", RX_BYTE, rx_q.pop_front());
      end
    end
    TX_WR = 1'b0;
    RX_TAKE = 1'b0;
    tick();
    check_val("rand_tx_q_drained", tx_q.size(), 0);
    check_val("rand_rx_q_drained", rx_q.size(), 0);
    check_val("rand_tx_count", TX_COUNT, tx_pushed[15:0]);
    check_val("rand_rx_count", RX_COUNT, rx_written[15:0]);
    check_val("rand_tx_empty", TX_EMPTY, 1);
    check_val("rand_rx_valid", RX_VALID, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mcu_link_controller.md
# mcu_link_controller

MCU-side endpoint of the 6502–MCU mailbox. It drives the mailbox's `TX_LOAD` and `RX_ACK` strobes and watches its `TX_AVAIL`, `RX_READY`, `DATA_TAKEN` and `DATA_WRITTEN` flags. It feeds bytes from a small TX FIFO into the TX latch and drains the RX latch into a valid/ready output register. It sits in the MCU-clock FPGA fabric; all mailbox flags arrive asynchronously (PHI2 domain) and are synchronized here.

## Interface
Parameters:
- `TX_DEPTH`, 4: TX FIFO depth; power of two, ≥2.
- `PULSE_CYCLES`, 2: width of each `TX_LOAD` / `RX_ACK` pulse, in CLK cycles; ≥1.
- `SYNC_STAGES`, 2: flip-flop synchronizer depth for each mailbox flag; ≥2.
- `RD_SETTLE`, 2: cycles `RX_OE_N` is held low before `RX_DATA` is sampled; ≥1.

Ports:
- `CLK`  in  1  MCU-side clock; one clock, all state on its rising edge.
- `RST`  in  1  reset; asynchronous, active-high.
- `TX_WR`  in  1  push `TX_WDATA` into the TX FIFO; ignored when `TX_FULL`.
- `TX_WDATA`  in  8  byte for the CPU.
- `TX_FULL`  out  1  TX FIFO full.
- `TX_EMPTY`  out  1  TX FIFO empty, and no byte in flight.
- `RX_VALID`  out  1  `RX_BYTE` holds an unconsumed byte from the CPU.
- `RX_BYTE`  out  8  received byte.
- `RX_TAKE`  in  1  consumer ready; the byte is consumed on a cycle where `RX_VALID & RX_TAKE`.
- `TX_DATA`  out  8  data to the TX latch inputs.
- `TX_LOAD`  out  1  TX latch load strobe to the mailbox.
- `RX_DATA`  in  8  RX latch outputs.
- `RX_OE_N`  out  1  RX latch output enable, active-low.
- `RX_ACK`  out  1  RX acknowledge strobe to the mailbox.
- `TX_AVAIL`, `RX_READY`, `DATA_TAKEN`, `DATA_WRITTEN`  in  1 each  asynchronous mailbox flags.
- `TX_COUNT`, `RX_COUNT`  out  16 each  bytes transferred in each direction; wrap modulo 2^16.

## Operation
- Synchronizers: each flag passes through `SYNC_STAGES` flip-flops. The `_s` suffix below denotes the synchronized value.
- Reset values:
  - `TX_LOAD`=0, `RX_ACK`=0, `RX_OE_N`=1, `TX_DATA`=0.
  - `RX_VALID`=0, `RX_BYTE`=0, both counts 0.
  - FIFO empty, so `TX_EMPTY`=1 and `TX_FULL`=0.
  - Synchronizer flops reset to 0.
- TX FSM:
  - T_IDLE → T_SETUP when the FIFO is non-empty and `TX_AVAIL_s`=0. On that transition it pops the FIFO head into `TX_DATA`.
  - T_SETUP (1 cycle) → T_PULSE.
  - T_PULSE: `TX_LOAD`=1 for `PULSE_CYCLES` cycles → T_BLIND.
  - T_BLIND: hold for `SYNC_STAGES`+1 cycles so the synchronized `TX_AVAIL` reflects the load → T_IDLE.
  - `TX_COUNT` increments on entry to T_BLIND.
  - `TX_DATA` is held from T_SETUP until the next pop.
  - A CPU read during T_BLIND needs no special handling: `TX_AVAIL` is already 0 when T_IDLE resumes.
- RX FSM:
  - R_INIT: `RX_ACK`=1 for `PULSE_CYCLES` starting the first cycle after `RST` deasserts, to arm `RX_READY` → R_IDLE.
  - R_IDLE → R_READ when `DATA_WRITTEN_s`=1 and the output slot is free. The slot is free when `RX_VALID`=0, or when `RX_VALID & RX_TAKE` on this cycle.
  - R_READ: `RX_OE_N`=0 for `RD_SETTLE` cycles. On the last cycle, sample `RX_DATA` into `RX_BYTE` and set `RX_VALID` → R_ACK.
  - R_ACK: `RX_ACK`=1 for `PULSE_CYCLES`; `RX_COUNT` increments on entry → R_CLEAR.
  - R_CLEAR: wait until `DATA_WRITTEN_s`=0 → R_IDLE. This prevents double capture of one byte.
- FIFO boundaries:
  - A push and a pop on the same cycle are both honoured; the level is unchanged.
  - A push when full is dropped. The pop side never underflows, since it is gated by non-empty.
  - Pointers are `log2(TX_DEPTH)`+1 bits, so full and empty are distinguished.
- Simultaneous `RX_TAKE` and a new capture: the capture wins; `RX_VALID` stays 1 with the new byte.
- Reset mid-operation:
  - Strobes drop asynchronously and the FIFO is cleared.
  - Any byte in flight or held in `RX_BYTE` is lost.
  - R_INIT runs again after release.

## Timing
- TX latency: a `TX_WR` at cycle 0 into an empty FIFO, with `TX_AVAIL_s`=0:
  - cycle 1: T_IDLE sees non-empty.
  - cycle 2: T_SETUP, with `TX_DATA` valid.
  - cycles 3 .. 2+`PULSE_CYCLES`: `TX_LOAD` high.
- `TX_DATA` is stable ≥1 cycle before `TX_LOAD` rises and throughout the pulse.
- Minimum TX period per byte: 1 + 1 + `PULSE_CYCLES` + `SYNC_STAGES` + 1 cycles. This is 7 with the default parameters; back-to-back bytes additionally wait for the CPU read.
- RX latency: from `DATA_WRITTEN` rising to `RX_VALID`, `SYNC_STAGES` + 1 + `RD_SETTLE` cycles.
- `RX_OE_N` is low only in R_READ; `RX_ACK` never overlaps `RX_OE_N`=0.

## Test plan
- Reset release: `RX_ACK` is high for exactly 2 cycles starting the first cycle after `RST` falls; all other outputs are at their reset values.
- Single TX: push 0xA5 with `TX_AVAIL`=0 → `TX_DATA`=0xA5 at cycle 2, `TX_LOAD` high in cycles 3–4, `TX_COUNT`=1. Hold `TX_AVAIL`=1 and push 0x3C → no second `TX_LOAD` until `TX_AVAIL` drops.
- FIFO full: with `TX_AVAIL` held 1, 4 pushes fill the FIFO and a 5th push → `TX_FULL`=1 and the 5th byte is dropped. Then toggle `TX_AVAIL` for each byte → 0x01, 0x02, 0x03, 0x04 are delivered in order, ending with `TX_EMPTY`=1.
- Single RX: `RX_DATA`=0x5A and a `DATA_WRITTEN` pulse → `RX_OE_N` low 2 cycles, `RX_VALID`=1 with `RX_BYTE`=0x5A, one 2-cycle `RX_ACK`. `DATA_WRITTEN` held high into R_CLEAR does not cause a second capture.
- RX backpressure: with `RX_TAKE`=0 and a second byte 0x66 written → no `RX_OE_N`/`RX_ACK` until `RX_TAKE`. The first byte is kept, then 0x66 arrives and `RX_COUNT`=2.
- Reset mid-T_PULSE → `TX_LOAD` falls within the same cycle, the FIFO is empty, and the R_INIT `RX_ACK` pulse recurs.
